// File: rtl/mem_pkg.sv
// mem_pkg: access-width codes, scheduler state encoding and lane helper shared by mem_sched
package mem_pkg;
  localparam logic [1:0] MEM_ACC_8  = 2'b00;
  localparam logic [1:0] MEM_ACC_16 = 2'b01;
  localparam logic [1:0] MEM_ACC_32 = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  function automatic int lanes(input int m_width);
    return m_width / 8;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane write mask, write-data replication, read alignment and access checks
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int M_WIDTH = 32
) (
  input  logic [$clog2(M_WIDTH/8)-1:0] off,
  input  logic [1:0]                   width,
  input  logic [M_WIDTH-1:0]           wdata,
  input  logic [M_WIDTH-1:0]           rdata,
  output logic [M_WIDTH/8-1:0]         we,
  output logic [M_WIDTH-1:0]           wdata_rep,
  output logic [M_WIDTH-1:0]           rdata_al,
  output logic                         err
);
  localparam int L = lanes(M_WIDTH);
  logic [M_WIDTH-1:0] sh;
  always_comb begin
    err = (width == MEM_ACC_16 && off[0]) || (width == MEM_ACC_32 && off[1:0] != 2'b00) || width == 2'b11;
    we = err ? '0 : width == MEM_ACC_8 ? L'(1) << off : width == MEM_ACC_16 ? L'(3) << off : L'(15) << off;
    wdata_rep = width == MEM_ACC_8 ? {L{wdata[7:0]}} : width == MEM_ACC_16 ? {(L/2){wdata[15:0]}} : {(L/4){wdata[31:0]}};
    sh = rdata >> {off, 3'b000};
    rdata_al = err ? '0 : width == MEM_ACC_8 ? M_WIDTH'(sh[7:0]) : width == MEM_ACC_16 ? M_WIDTH'(sh[15:0]) : M_WIDTH'(sh[31:0]);
  end
endmodule

// File: rtl/mem_sched.sv
// mem_sched: multi-client scheduler running one SRAM access at a time (IDLE/ACCESS/WAIT/RESP)
// MEM_SCHED_FIXED_PRIO_EN selects fixed highest-index priority instead of round-robin.
module mem_sched
  import mem_pkg::*;
#(
  parameter int M_WIDTH    = 32,
  parameter int CLIENT_CNT = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CLIENT_CNT-1:0]              client_requests,
  input  logic [M_WIDTH*CLIENT_CNT-1:0]      client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]              client_wes,
  input  logic [2*CLIENT_CNT-1:0]            client_data_widths_packed,
  input  logic [M_WIDTH*CLIENT_CNT-1:0]      client_data_outs_packed,
  output logic [CLIENT_CNT-1:0]              client_readies,
  output logic [CLIENT_CNT-1:0]              client_errs,
  output logic [M_WIDTH*CLIENT_CNT-1:0]      client_data_ins_packed,
  input  logic [M_WIDTH-1:0]                 mem_data_in,
  output logic [M_WIDTH-1:0]                 mem_data_out,
  output logic [M_WIDTH-$clog2(M_WIDTH/8)-1:0] mem_addr,
  output logic [M_WIDTH/8-1:0]               mem_we_outs
);
  localparam int OB = $clog2(lanes(M_WIDTH));
  localparam int IW = CLIENT_CNT > 1 ? $clog2(CLIENT_CNT) : 1;
  state_t state, state_d;
  logic [IW-1:0] rr, rr_nxt, win, win_q, idx;
  logic [OB-1:0] off_q, a_off;
  logic [1:0] width_q, a_width, w_width;
  logic err_q, w_we, al_err;
  logic [M_WIDTH-1:0] w_addr, w_wdata, al_wdata, al_rdata;
  logic [M_WIDTH/8-1:0] al_we;
`ifdef MEM_SCHED_FIXED_PRIO_EN
  always_comb begin
    idx = '0;
    win = '0;
    for (int i = 0; i < CLIENT_CNT; i++) if (client_requests[i]) win = IW'(i);
  end
  assign rr_nxt = '0;
`else
  // Descending scan so the requester closest to rr (inclusive) is the last to overwrite win.
  always_comb begin
    idx = '0;
    win = '0;
    for (int i = CLIENT_CNT - 1; i >= 0; i--) begin
      idx = IW'((int'(rr) + i) % CLIENT_CNT);
      if (client_requests[idx]) win = idx;
    end
  end
  assign rr_nxt = win_q == IW'(CLIENT_CNT - 1) ? '0 : win_q + 1'b1;
`endif
  assign w_addr  = client_addrs_packed[win*M_WIDTH +: M_WIDTH];
  assign w_wdata = client_data_outs_packed[win*M_WIDTH +: M_WIDTH];
  assign w_width = client_data_widths_packed[win*2 +: 2];
  assign w_we    = client_wes[win];
  // The aligner serves the incoming winner in IDLE and the latched access afterwards.
  assign a_off   = state == IDLE ? w_addr[OB-1:0] : off_q;
  assign a_width = state == IDLE ? w_width : width_q;
  mem_lane_align #(.M_WIDTH(M_WIDTH)) u_align (
    .off(a_off),
    .width(a_width),
    .wdata(w_wdata),
    .rdata(mem_data_in),
    .we(al_we),
    .wdata_rep(al_wdata),
    .rdata_al(al_rdata),
    .err(al_err)
  );
  always_comb begin
    state_d = state == IDLE ? (|client_requests ? ACCESS : IDLE) : state == ACCESS ? WAIT : state == WAIT ? RESP : IDLE;
    client_readies = '0;
    client_errs = '0;
    if (state == RESP) begin
      client_readies[win_q] = 1'b1;
      client_errs[win_q] = err_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr <= '0;
      win_q <= '0;
      off_q <= '0;
      width_q <= '0;
      err_q <= 1'b0;
      mem_addr <= '0;
      mem_we_outs <= '0;
      mem_data_out <= '0;
      client_data_ins_packed <= '0;
    end else begin
      state <= state_d;
      mem_we_outs <= '0;
      if (state == IDLE && state_d == ACCESS) begin
        win_q <= win;
        off_q <= w_addr[OB-1:0];
        width_q <= w_width;
        err_q <= al_err;
        mem_addr <= w_addr[M_WIDTH-1:OB];
        mem_we_outs <= w_we ? al_we : '0;
        mem_data_out <= al_wdata;
      end
      if (state == WAIT) client_data_ins_packed[win_q*M_WIDTH +: M_WIDTH] <= al_rdata;
      if (state == RESP) rr <= rr_nxt;
    end
  end
endmodule
